// File: rtl/xalu.sv
`default_nettype none
// ============================================================================
// Module   : xalu
// Brief    : Multi-cycle multiply/divide unit with HI/LO registers and a
//            registered Busy handshake for the E-stage stall unit.
// Revision : 1.0 - initial release
// ============================================================================
module xalu #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  XALUOp,
    input  logic        Start,
    input  logic        IntReq,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_max_lat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int c_cnt_w   = $clog2(c_max_lat + 1);

    localparam logic [c_cnt_w-1:0] c_mult_lat = c_cnt_w'(MULT_LAT);
    localparam logic [c_cnt_w-1:0] c_div_lat  = c_cnt_w'(DIV_LAT);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [3:0] c_op_mult  = 4'd1;
    localparam logic [3:0] c_op_multu = 4'd2;
    localparam logic [3:0] c_op_div   = 4'd3;
    localparam logic [3:0] c_op_divu  = 4'd4;
    localparam logic [3:0] c_op_mthi  = 4'd5;
    localparam logic [3:0] c_op_mtlo  = 4'd6;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_count;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_is_signed;
    logic               w_acc;
    logic               w_acc_md;
    logic               w_commit;
    logic [63:0]        w_prod;
    logic [31:0]        w_dvd;
    logic [31:0]        w_dvs;
    logic [31:0]        w_q_mag;
    logic [31:0]        w_r_mag;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    assign w_is_mul    = (XALUOp == c_op_mult) || (XALUOp == c_op_multu);
    assign w_is_div    = (XALUOp == c_op_div)  || (XALUOp == c_op_divu);
    assign w_is_signed = (XALUOp == c_op_mult) || (XALUOp == c_op_div);

    // Busy is exactly the RUN state, so gating on IDLE also blocks Start while busy.
    assign w_acc    = Start && !IntReq && (r_state == c_st_idle);
    assign w_acc_md = w_acc && (w_is_mul || w_is_div);
    assign w_commit = (r_state == c_st_run) && (r_count == c_cnt_one);

    assign w_prod = w_is_signed
                  ? 64'($signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B}))
                  : ({32'd0, A} * {32'd0, B});

    // Signed divide on magnitudes; 0x80000000 / -1 folds back to 0x80000000 rem 0.
    assign w_a_neg = w_is_signed && A[31];
    assign w_b_neg = w_is_signed && B[31];
    assign w_dvd   = w_a_neg ? (32'd0 - A) : A;
    assign w_dvs   = w_b_neg ? (32'd0 - B) : B;
    assign w_q_mag = w_dvd / w_dvs;
    assign w_r_mag = w_dvd % w_dvs;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        if (w_is_mul) begin
            w_res_hi = w_prod[63:32];
            w_res_lo = w_prod[31:0];
        end else if (B == 32'd0) begin
            w_res_hi = A;
            w_res_lo = 32'hFFFF_FFFF;
        end else begin
            w_res_lo = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
            w_res_hi = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_acc_md) w_state_nxt = c_st_run;
            c_st_run:  if (w_commit) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            if (w_acc_md) begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_count   <= w_is_mul ? c_mult_lat : c_div_lat;
            end else if (r_state == c_st_run) begin
                r_count <= r_count - c_cnt_one;
            end

            if (w_commit) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end else if (w_acc && (XALUOp == c_op_mthi)) begin
                r_hi <= A;
            end else if (w_acc && (XALUOp == c_op_mtlo)) begin
                r_lo <= A;
            end
        end
    end

    assign Busy = (r_state == c_st_run);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_xalu.sv
`default_nettype none
// ============================================================================
// Module   : tb_xalu
// Brief    : Self-checking bench for xalu against a behavioural HI/LO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xalu;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  XALUOp;
    logic        Start;
    logic        IntReq;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    always #5 clk = ~clk;

    xalu #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .XALUOp(XALUOp),
        .Start(Start), .IntReq(IntReq), .Busy(Busy), .HI(HI), .LO(LO)
    );

    // Architectural result {HI,LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (op)
            4'd1: return sa * sb;
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] op);
        return (op <= 4'd2) ? MULT_LAT : DIV_LAT;
    endfunction

    // Called at a negedge; leaves the bench at the negedge of cycle T+1.
    task automatic pulse_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic irq);
        XALUOp = op; A = a; B = b; IntReq = irq; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; IntReq = 1'b0; XALUOp = 4'd0; A = $urandom; B = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1; Start = 1'b0; IntReq = 1'b0; XALUOp = 4'd0; A = 32'd0; B = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({Busy, HI, LO} !== 65'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h, want 0/0/0", Busy, HI, LO);
        end
        reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        XALUOp = 4'd5; A = 32'h1234_5678; Start = 1'b1;
        @(negedge clk);
        exp_hi = 32'h1234_5678;
        checks++;
        if ({Busy, HI, LO} !== {1'b0, exp_hi, exp_lo}) begin
            errors++;
            $display("FAIL mthi: busy=%b hi=%h lo=%h, want 0/%h/%h", Busy, HI, LO, exp_hi, exp_lo);
        end
        XALUOp = 4'd6; A = 32'h9ABC_DEF0;
        @(negedge clk);
        Start = 1'b0; XALUOp = 4'd0;
        exp_lo = 32'h9ABC_DEF0;
        checks++;
        if ({Busy, HI, LO} !== {1'b0, exp_hi, exp_lo}) begin
            errors++;
            $display("FAIL mtlo: busy=%b hi=%h lo=%h, want 0/%h/%h", Busy, HI, LO, exp_hi, exp_lo);
        end
    endtask

    task automatic test_mult_timing();
        pulse_start(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        for (int k = 1; k <= MULT_LAT; k++) begin
            checks++;
            if ({Busy, HI, LO} !== {1'b1, exp_hi, exp_lo}) begin
                errors++;
                $display("FAIL mult_busy c%0d: busy=%b hi=%h lo=%h, want 1/%h/%h", k, Busy, HI, LO, exp_hi, exp_lo);
            end
            @(negedge clk);
        end
        exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFA;
        checks++;
        if ({Busy, HI, LO} !== {1'b0, exp_hi, exp_lo}) begin
            errors++;
            $display("FAIL mult_commit: busy=%b hi=%h lo=%h, want 0/%h/%h", Busy, HI, LO, exp_hi, exp_lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [2] = '{4'd4, 4'd3};
        logic [31:0] as  [2] = '{32'd100, 32'hFFFF_FFF9};
        logic [31:0] bs  [2] = '{32'd7, 32'd2};
        logic [63:0] want[2] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        for (int n = 0; n < 2; n++) begin
            pulse_start(ops[n], as[n], bs[n], 1'b0);
            for (int k = 1; k <= DIV_LAT; k++) begin
                checks++;
                if ({Busy, HI, LO} !== {1'b1, exp_hi, exp_lo}) begin
                    errors++;
                    $display("FAIL b2b%0d_busy c%0d: busy=%b hi=%h lo=%h, want 1/%h/%h", n, k, Busy, HI, LO, exp_hi, exp_lo);
                end
                @(negedge clk);
            end
            {exp_hi, exp_lo} = want[n];
            checks++;
            if ({Busy, HI, LO} !== {1'b0, exp_hi, exp_lo}) begin
                errors++;
                $display("FAIL b2b%0d_commit: busy=%b hi=%h lo=%h, want 0/%h/%h", n, Busy, HI, LO, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_boundary();
        logic [3:0]  ops [3] = '{4'd3, 4'd4, 4'd3};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'd5, 32'hFFFF_FFF0};
        logic [31:0] bs  [3] = '{32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [63:0] want[3] = '{{32'd0, 32'h8000_0000}, {32'd5, 32'hFFFF_FFFF}, {32'hFFFF_FFF0, 32'hFFFF_FFFF}};
        for (int n = 0; n < 3; n++) begin
            pulse_start(ops[n], as[n], bs[n], 1'b0);
            repeat (DIV_LAT) @(negedge clk);
            {exp_hi, exp_lo} = want[n];
            checks++;
            if ({Busy, HI, LO} !== {1'b0, exp_hi, exp_lo}) begin
                errors++;
                $display("FAIL boundary%0d: busy=%b hi=%h lo=%h, want 0/%h/%h", n, Busy, HI, LO, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_intreq();
        pulse_start(4'd1, 32'd7, 32'd9, 1'b1);
        for (int k = 1; k <= MULT_LAT + 2; k++) begin
            checks++;
            if ({Busy, HI, LO} !== {1'b0, exp_hi, exp_lo}) begin
                errors++;
                $display("FAIL intreq_block c%0d: busy=%b hi=%h lo=%h, want 0/%h/%h", k, Busy, HI, LO, exp_hi, exp_lo);
            end
            @(negedge clk);
        end
        pulse_start(4'd1, 32'd7, 32'd9, 1'b0);
        @(negedge clk);
        IntReq = 1'b1;
        @(negedge clk);
        IntReq = 1'b0;
        repeat (MULT_LAT - 2) @(negedge clk);
        exp_hi = 32'd0; exp_lo = 32'd63;
        checks++;
        if ({Busy, HI, LO} !== {1'b0, exp_hi, exp_lo}) begin
            errors++;
            $display("FAIL intreq_midrun: busy=%b hi=%h lo=%h, want 0/%h/%h", Busy, HI, LO, exp_hi, exp_lo);
        end
    endtask

    task automatic test_invalid_op();
        logic [3:0] ops[4] = '{4'd0, 4'd7, 4'd9, 4'd15};
        for (int n = 0; n < 4; n++) begin
            pulse_start(ops[n], $urandom, $urandom, 1'b0);
            @(negedge clk);
            checks++;
            if ({Busy, HI, LO} !== {1'b0, exp_hi, exp_lo}) begin
                errors++;
                $display("FAIL invalid_op %0d: busy=%b hi=%h lo=%h, want 0/%h/%h", ops[n], Busy, HI, LO, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_random_arith();
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [63:0] want;
        int          lat;
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(1, 4));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            want = ref_result(op, a, b);
            lat  = lat_of(op);
            pulse_start(op, a, b, 1'b0);
            for (int k = 1; k <= lat; k++) begin
                checks++;
                if ({Busy, HI, LO} !== {1'b1, exp_hi, exp_lo}) begin
                    errors++;
                    $display("FAIL rand%0d_busy c%0d: busy=%b hi=%h lo=%h, want 1/%h/%h", n, k, Busy, HI, LO, exp_hi, exp_lo);
                end
                // Noise while busy: interrupts and an mthi Start must both be ignored.
                IntReq = 1'($urandom_range(0, 1));
                Start  = (k == 2);
                XALUOp = 4'd5;
                A      = $urandom;
                @(negedge clk);
                IntReq = 1'b0; Start = 1'b0; XALUOp = 4'd0;
            end
            {exp_hi, exp_lo} = want;
            checks++;
            if ({Busy, HI, LO} !== {1'b0, exp_hi, exp_lo}) begin
                errors++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: busy=%b hi=%h lo=%h, want 0/%h/%h",
                         n, op, a, b, Busy, HI, LO, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_reset_mid();
        pulse_start(4'd3, 32'd1000, 32'd3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        checks++;
        if ({Busy, HI, LO} !== 65'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h, want 0/0/0", Busy, HI, LO);
        end
        repeat (DIV_LAT + 2) @(negedge clk);
        checks++;
        if ({Busy, HI, LO} !== 65'd0) begin
            errors++;
            $display("FAIL reset_no_commit: busy=%b hi=%h lo=%h, want 0/0/0", Busy, HI, LO);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mthi_mtlo();
        test_mult_timing();
        test_back_to_back();
        test_boundary();
        test_intreq();
        test_invalid_op();
        test_random_arith();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xalu.md
Name: xalu

Overview:
- Multi-cycle multiply/divide unit in the E stage, with HI/LO registers. Producer of the Busy handshake consumed by the stall unit.
- Accepts one operation per Start pulse.
- Holds Busy for a fixed per-class latency, then commits results to HI/LO atomically.
- Honours IntReq so an E-stage operation flushed by an interrupt never starts.

Parameters:
MULT_LAT, 5, cycles Busy stays high for mult/multu
DIV_LAT, 10, cycles Busy stays high for div/divu

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
A  input  32  rs operand (forwarded value in E)
B  input  32  rt operand (forwarded value in E)
XALUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7-15 treated as none
Start  input  1  one-cycle pulse; E-stage instruction is an XALU op
IntReq  input  1  interrupt/exception taken this cycle; suppresses Start
Busy  output  1  operation in progress
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset: Busy=0, HI=0, LO=0, counter=0, pending results=0. Reset mid-operation aborts it; no commit.
- Accept condition: acc = Start && !IntReq && !Busy && XALUOp in 1..6. Start while Busy is ignored (the stall unit prevents it). Start with IntReq=1 has no effect at all.
- mult/multu/div/divu accepted at edge T:
  - Results are computed from A, B as sampled at T and held in pending registers.
  - counter loads MULT_LAT or DIV_LAT.
  - Busy=1 during cycles T+1 .. T+LAT. Busy falls at edge T+LAT.
  - HI/LO take the pending values at that same edge (edge T+LAT), so they are visible from cycle T+LAT+1.
  - HI/LO hold their old values throughout Busy.
- mthi/mtlo accepted at edge T: HI (or LO) = A at that edge, visible in cycle T+1. Busy never asserts. The other register is unchanged.
- FSM states:
  - IDLE: Busy=0. On acc of a mul/div, go to RUN.
  - RUN: counter decrements each cycle. At counter==1, commit HI/LO and go to IDLE.
  - A back-to-back Start in the cycle right after Busy falls is accepted normally.
- Arithmetic:
  - mult: {HI,LO} = signed(A)*signed(B), 64-bit.
  - multu: {HI,LO} = unsigned product.
  - div: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Boundary cases:
  - div by zero (signed or unsigned): LO=0xFFFFFFFF, HI=A.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- IntReq during RUN does not cancel: the operation was issued by an older, committed instruction, so it completes and commits.
- No combinational path from Start to Busy. Busy is purely registered.

Test Plan:
- mult, A=0xFFFFFFFE (-2), B=3, Start at T with MULT_LAT=5 -> Busy=1 in cycles T+1..T+5; HI=0xFFFFFFFF, LO=0xFFFFFFFA from cycle T+6; HI/LO unchanged earlier.
- divu A=100, B=7, then div A=-7 (0xFFFFFFF9), B=2 -> first: LO=14, HI=2 after 10 Busy cycles; second: LO=0xFFFFFFFD, HI=0xFFFFFFFF. Second Start issued the cycle after Busy falls is accepted.
- div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. divu A=5, B=0 -> LO=0xFFFFFFFF, HI=5.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles -> HI visible the next cycle, LO the cycle after; Busy stays 0.
- Start(mult) together with IntReq=1 -> Busy stays 0, HI/LO unchanged. IntReq pulsed mid-RUN -> result still commits on schedule.
- reset asserted in cycle T+3 of a div -> Busy=0, HI=LO=0 the next cycle; no later commit.
